// File: rtl/sseg_pkg.sv
// Shared seven-segment definitions: code table, blank code, scan FSM states.
// Used by the scan decoder and by any hex_to_sseg encoder.
package sseg_pkg;

    localparam logic [15:0][6:0] SSEG_CODES = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    localparam logic [6:0] SSEG_BLANK = 7'h7F;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_HOLD
    } scan_state_e;

    function automatic logic [6:0] hex_to_sseg(input logic [3:0] nib);
        return SSEG_CODES[nib];
    endfunction

endpackage

// File: rtl/sseg_pattern_decode.sv
// Combinational active-low segment pattern to nibble decoder.
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] pattern_i,
    output logic [3:0] nibble_o,
    output logic       valid_o,
    output logic       blank_o
);

    always_comb begin
        nibble_o = '0;
        valid_o  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            if (pattern_i == SSEG_CODES[i]) begin
                nibble_o = 4'(i);
                valid_o  = 1'b1;
            end
        end
    end

    assign blank_o = (pattern_i == SSEG_BLANK);

endmodule

// File: rtl/sseg_scan_decoder.sv
// Multiplexed seven-segment scan decoder with debounce, frame assembly, error flag.
// Optional SSEG_DP_CAPTURE_EN adds decimal-point input dp and output dp_word.
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic [6:0]              sseg,
`ifdef SSEG_DP_CAPTURE_EN
    input  logic                    dp,
    output logic [NUM_DIGITS-1:0]   dp_word,
`endif
    input  logic                    err_clr,
    output logic [4*NUM_DIGITS-1:0] hex_word,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic [4*NUM_DIGITS-1:0] frame_word,
    output logic                    frame_valid,
    output logic                    err_pattern,
    output logic [2:0]              err_digit
);

`ifdef SSEG_DP_CAPTURE_EN
    localparam int SW = NUM_DIGITS + 8;
    logic [SW-1:0] samp;
    logic [NUM_DIGITS-1:0] dpw_q;
    assign samp    = {dp, an, sseg};
    assign dp_word = dpw_q;
`else
    localparam int SW = NUM_DIGITS + 7;
    logic [SW-1:0] samp;
    assign samp = {an, sseg};
`endif

    localparam logic [7:0] CAP_CNT = 8'(STABLE_CYCLES - 1);

    logic [SW-1:0]           in_q;
    logic [7:0]              cnt_q;
    scan_state_e             st_q;
    logic [NUM_DIGITS-1:0]   seen_q;
    logic [NUM_DIGITS-1:0]   dv_q;
    logic [4*NUM_DIGITS-1:0] hex_q;
    logic [4*NUM_DIGITS-1:0] frm_q;
    logic                    fv_q;
    logic                    err_q;
    logic [2:0]              errd_q;

    logic                    samp_oc;
    logic                    changed;
    logic                    capture;
    logic [NUM_DIGITS-1:0]   cap_sel;
    logic [2:0]              cap_idx;
    logic [4*NUM_DIGITS-1:0] hex_d;
    logic [NUM_DIGITS-1:0]   seen_d;
    logic [3:0]              nib;
    logic                    nib_ok;
    logic                    nib_blank;

    sseg_pattern_decode u_dec (
        .pattern_i (in_q[6:0]),
        .nibble_o  (nib),
        .valid_o   (nib_ok),
        .blank_o   (nib_blank)
    );

    assign samp_oc = $onehot(~samp[NUM_DIGITS+6:7]);
    assign changed = (samp != in_q);
    assign capture = (st_q == ST_SETTLE) && (cnt_q == CAP_CNT);
    assign cap_sel = ~in_q[NUM_DIGITS+6:7];
    assign seen_d  = seen_q | cap_sel;

    always_comb begin
        cap_idx = '0;
        hex_d   = hex_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (cap_sel[i]) begin
                cap_idx          = 3'(i);
                hex_d[4*i +: 4]  = nib;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_q   <= '0;
            cnt_q  <= '0;
            st_q   <= ST_IDLE;
            seen_q <= '0;
            dv_q   <= '0;
            hex_q  <= '0;
            frm_q  <= '0;
            fv_q   <= 1'b0;
            err_q  <= 1'b0;
            errd_q <= '0;
`ifdef SSEG_DP_CAPTURE_EN
            dpw_q  <= '0;
`endif
        end else begin
            fv_q <= 1'b0;
            in_q <= samp;
            if (err_clr) begin
                err_q <= 1'b0;
            end
            if (changed) begin
                cnt_q <= '0;
            end else if (cnt_q != 8'hFF) begin
                cnt_q <= cnt_q + 8'd1;
            end
            if (!samp_oc) begin
                st_q <= ST_IDLE;
            end else if (changed) begin
                st_q <= ST_SETTLE;
            end else if (capture) begin
                st_q <= ST_HOLD;
                if (nib_ok) begin
                    hex_q <= hex_d;
                    dv_q  <= dv_q | cap_sel;
`ifdef SSEG_DP_CAPTURE_EN
                    dpw_q <= (dpw_q & ~cap_sel)
                           | (cap_sel & {NUM_DIGITS{~in_q[SW-1]}});
`endif
                    // Frame completes when every digit has been seen once.
                    if (&seen_d) begin
                        fv_q   <= 1'b1;
                        frm_q  <= hex_d;
                        seen_q <= '0;
                    end else begin
                        seen_q <= seen_d;
                    end
                end else if (!nib_blank) begin
                    err_q  <= 1'b1;
                    errd_q <= cap_idx;
                end
            end
        end
    end

    assign hex_word    = hex_q;
    assign digit_valid = dv_q;
    assign frame_word  = frm_q;
    assign frame_valid = fv_q;
    assign err_pattern = err_q;
    assign err_digit   = errd_q;

endmodule

// File: tb/tb_sseg_scan_decoder.sv
// Directed bench for sseg_scan_decoder with a frame scoreboard.
module tb_sseg_scan_decoder;

    localparam int N = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   an = '1;
    logic [6:0]     sseg = 7'h7F;
    logic           err_clr = 1'b0;
    logic [4*N-1:0] hex_word;
    logic [N-1:0]   digit_valid;
    logic [4*N-1:0] frame_word;
    logic           frame_valid;
    logic           err_pattern;
    logic [2:0]     err_digit;
`ifdef SSEG_DP_CAPTURE_EN
    logic           dp = 1'b1;
    logic [N-1:0]   dp_word;
`endif

    int tests = 0;
    int fails = 0;
    int frames = 0;
    logic [31:0] frame_q[$];
    logic [6:0] codes [8] = '{7'h79, 7'h24, 7'h30, 7'h19,
                              7'h12, 7'h02, 7'h78, 7'h00};

    sseg_scan_decoder #(
        .NUM_DIGITS    (N),
        .STABLE_CYCLES (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .an          (an),
        .sseg        (sseg),
`ifdef SSEG_DP_CAPTURE_EN
        .dp          (dp),
        .dp_word     (dp_word),
`endif
        .err_clr     (err_clr),
        .hex_word    (hex_word),
        .digit_valid (digit_valid),
        .frame_word  (frame_word),
        .frame_valid (frame_valid),
        .err_pattern (err_pattern),
        .err_digit   (err_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [6:0] s);
        an   = a;
        sseg = s;
    endtask

    task automatic do_reset();
        rst_n   = 1'b0;
        an      = '1;
        sseg    = 7'h7F;
        err_clr = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
    endtask

    always @(negedge clk) begin
        if (rst_n && frame_valid) begin
            frames++;
            if (frame_q.size() == 0)
                check("frame_unexpected", 64'(frame_valid), 64'd0);
            else
                check("frame_word", 64'(frame_word), 64'(frame_q.pop_front()));
        end
    end

    initial begin
        tick(2);
        check("rst_hex", 64'(hex_word), 64'd0);
        check("rst_dv", 64'(digit_valid), 64'd0);
        check("rst_fw", 64'(frame_word), 64'd0);
        check("rst_fv", 64'(frame_valid), 64'd0);
        check("rst_err", 64'(err_pattern), 64'd0);
        check("rst_errd", 64'(err_digit), 64'd0);
        rst_n = 1'b1;
        tick(1);

        // single digit dwell: capture on the fifth edge after the change
        drive(8'hFE, 7'h40);
        tick(4);
        check("dwell_early_dv", 64'(digit_valid), 64'd0);
        tick(1);
        check("dwell_dv", 64'(digit_valid), 64'h01);
        check("dwell_hex", 64'(hex_word), 64'd0);
        tick(20);
        check("hold_dv", 64'(digit_valid), 64'h01);
        check("hold_fv_count", 64'(frames), 64'd0);
        drive(8'hFE, 7'h24);
        tick(5);
        check("recap_d0_hex", 64'(hex_word), 64'h2);

        // full frame scan
        do_reset();
        frame_q.push_back(32'h87654321);
        for (int d = 7; d >= 0; d--) begin
            drive(~(8'h01 << d), codes[d]);
            tick(6);
        end
        check("scan_dv", 64'(digit_valid), 64'hFF);
        check("scan_hex", 64'(hex_word), 64'h87654321);
        check("scan_frames", 64'(frames), 64'd1);
        drive(8'hF7, 7'h08);
        tick(6);
        check("recap_hex", 64'(hex_word), 64'h8765A321);
        check("recap_frames", 64'(frames), 64'd1);

        // blank, error, clear, clear colliding with new error
        do_reset();
        drive(8'hFD, 7'h7F);
        tick(8);
        check("blank_err", 64'(err_pattern), 64'd0);
        check("blank_dv", 64'(digit_valid), 64'd0);
        drive(8'hFD, 7'h55);
        tick(8);
        check("bad_err", 64'(err_pattern), 64'd1);
        check("bad_errd", 64'(err_digit), 64'd1);
        check("bad_hex", 64'(hex_word), 64'd0);
        check("bad_dv", 64'(digit_valid), 64'd0);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr_err", 64'(err_pattern), 64'd0);
        drive(8'hFB, 7'h55);
        tick(4);
        err_clr = 1'b1;
        tick(1);
        err_clr = 1'b0;
        check("clr_vs_new_err", 64'(err_pattern), 64'd1);
        check("clr_vs_new_errd", 64'(err_digit), 64'd2);

        // unstable input and a dwell one edge short
        do_reset();
        for (int k = 0; k < 10; k++) begin
            drive(8'hFE, (k % 2 == 1) ? 7'h79 : 7'h40);
            tick(3);
        end
        check("toggle_dv", 64'(digit_valid), 64'd0);
        check("toggle_hex", 64'(hex_word), 64'd0);
        drive(8'hFE, 7'h24);
        tick(4);
        drive(8'hFF, 7'h7F);
        tick(4);
        check("short_dwell_dv", 64'(digit_valid), 64'd0);

        // non-one-cold strobes and reset mid-dwell
        do_reset();
        drive(8'hFC, 7'h40);
        tick(10);
        check("multi_dv", 64'(digit_valid), 64'd0);
        drive(8'hFC, 7'h55);
        tick(10);
        check("multi_err", 64'(err_pattern), 64'd0);
        drive(8'hFE, 7'h79);
        tick(2);
        rst_n = 1'b0;
        drive(8'hFF, 7'h7F);
        #2;
        check("midrst_hex", 64'(hex_word), 64'd0);
        check("midrst_dv", 64'(digit_valid), 64'd0);
        check("midrst_err", 64'(err_pattern), 64'd0);
        tick(1);
        rst_n = 1'b1;
        tick(10);
        check("postrst_dv", 64'(digit_valid), 64'd0);
        check("postrst_hex", 64'(hex_word), 64'd0);

`ifdef SSEG_DP_CAPTURE_EN
        do_reset();
        dp = 1'b0;
        drive(8'hFB, 7'h30);
        tick(6);
        dp = 1'b1;
        check("dp_word", 64'(dp_word), 64'h04);
        check("dp_hex", 64'(hex_word), 64'h300);
`endif

        check("frame_pending", 64'(frame_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
